// File: rtl/clause_check_scheduler.sv
// Clause-check scheduler: enables all checkers, waits for them, then scans for an
// unsatisfied clause from an LFSR-chosen start. Optional watchdog: CLAUSE_SCHED_TIMEOUT_EN.
module clause_check_scheduler #(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
  parameter logic [15:0] LFSR_SEED                          = 16'hACE1,
  parameter int unsigned TIMEOUT_CYCLES                     = 16
) (
  input  logic                                          in_clk,
  input  logic                                          in_reset,
  input  logic                                          in_start,
  input  logic                                          in_abort,
  input  logic                                          in_seed_valid,
  input  logic [15:0]                                   in_seed,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_checker_ready,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_clause_satisfied,
  input  logic                                          in_ack,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] out_checker_enable,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic                                          out_valid,
  output logic                                          out_formula_satisfied,
  output logic                                          out_error,
  output logic                                          out_busy
);

  localparam int unsigned K = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int unsigned N = 2 ** K;

  typedef enum logic [2:0] {StIdle, StEnable, StWait, StScan, StDone} state_e;

  state_e         r_state, w_state_d;
  logic [15:0]    r_lfsr, w_lfsr_d;
  logic [K-1:0]   r_ptr, w_ptr_d;
  logic [N-1:0]   r_capture, w_capture_d;
  logic [K-1:0]   r_index, w_index_d;
  logic           r_formula_sat, w_formula_sat_d;

  logic [15:0]    w_seed_eff;
  logic [15:0]    w_lfsr_src;
  logic [15:0]    w_lfsr_step;
  logic           w_all_ready;
  logic           w_all_sat;

`ifdef CLAUSE_SCHED_TIMEOUT_EN
  logic           r_error, w_error_d;
  logic [31:0]    r_wait_cnt, w_wait_cnt_d;
`endif

  // A seed loaded in the same cycle as start feeds the start pointer directly.
  assign w_seed_eff  = (in_seed == 16'h0000) ? LFSR_SEED : in_seed;
  assign w_lfsr_src  = in_seed_valid ? w_seed_eff : r_lfsr;
  assign w_lfsr_step = {w_lfsr_src[14:0],
                        w_lfsr_src[15] ^ w_lfsr_src[13] ^ w_lfsr_src[12] ^ w_lfsr_src[10]};
  assign w_all_ready = &in_checker_ready;
  assign w_all_sat   = &in_clause_satisfied;

  always_comb begin
    w_state_d       = r_state;
    w_lfsr_d        = r_lfsr;
    w_ptr_d         = r_ptr;
    w_capture_d     = r_capture;
    w_index_d       = r_index;
    w_formula_sat_d = r_formula_sat;
`ifdef CLAUSE_SCHED_TIMEOUT_EN
    w_error_d       = r_error;
    w_wait_cnt_d    = r_wait_cnt;
`endif
    if (in_abort) begin
      w_state_d       = StIdle;
      w_ptr_d         = '0;
      w_capture_d     = '0;
      w_index_d       = '0;
      w_formula_sat_d = 1'b0;
`ifdef CLAUSE_SCHED_TIMEOUT_EN
      w_error_d       = 1'b0;
      w_wait_cnt_d    = '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_seed_valid) w_lfsr_d = w_seed_eff;
          if (in_start) begin
            w_ptr_d         = w_lfsr_src[K-1:0];
            w_lfsr_d        = w_lfsr_step;
            w_index_d       = '0;
            w_formula_sat_d = 1'b0;
`ifdef CLAUSE_SCHED_TIMEOUT_EN
            w_error_d       = 1'b0;
`endif
            w_state_d       = StEnable;
          end
        end
        StEnable: begin
`ifdef CLAUSE_SCHED_TIMEOUT_EN
          w_wait_cnt_d = '0;
`endif
          w_state_d = StWait;
        end
        StWait: begin
          if (w_all_ready) begin
            w_capture_d = in_clause_satisfied;
            if (w_all_sat) begin
              w_formula_sat_d = 1'b1;
              w_index_d       = '0;
              w_state_d       = StDone;
            end else begin
              w_state_d = StScan;
            end
`ifdef CLAUSE_SCHED_TIMEOUT_EN
          end else if (r_wait_cnt == TIMEOUT_CYCLES - 1) begin
            w_error_d       = 1'b1;
            w_formula_sat_d = 1'b0;
            w_index_d       = '0;
            w_state_d       = StDone;
          end else begin
            w_wait_cnt_d = r_wait_cnt + 32'd1;
`endif
          end
        end
        StScan: begin
          // Capture is known not all-ones here, so this terminates within N cycles.
          if (!r_capture[r_ptr]) begin
            w_index_d = r_ptr;
            w_state_d = StDone;
          end else begin
            w_ptr_d = r_ptr + K'(1);
          end
        end
        StDone: begin
          if (in_ack) begin
            w_index_d       = '0;
            w_formula_sat_d = 1'b0;
`ifdef CLAUSE_SCHED_TIMEOUT_EN
            w_error_d       = 1'b0;
`endif
            w_state_d       = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state       <= StIdle;
      r_lfsr        <= LFSR_SEED;
      r_ptr         <= '0;
      r_capture     <= '0;
      r_index       <= '0;
      r_formula_sat <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_lfsr        <= w_lfsr_d;
      r_ptr         <= w_ptr_d;
      r_capture     <= w_capture_d;
      r_index       <= w_index_d;
      r_formula_sat <= w_formula_sat_d;
    end
  end

`ifdef CLAUSE_SCHED_TIMEOUT_EN
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_error    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_error    <= w_error_d;
      r_wait_cnt <= w_wait_cnt_d;
    end
  end

  assign out_error = r_error;
`else
  assign out_error = 1'b0;
`endif

  assign out_checker_enable    = {N{r_state == StEnable}};
  assign out_clause_index      = r_index;
  assign out_valid             = (r_state == StDone);
  assign out_formula_satisfied = r_formula_sat;
  assign out_busy              = (r_state != StIdle);

endmodule

// File: tb/tb_clause_check_scheduler.sv
// Directed bench for clause_check_scheduler: an LFSR/scan model pushes expected results,
// which are popped and compared when out_valid rises.
module tb_clause_check_scheduler;

  localparam int K = 3;
  localparam int N = 8;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           seed_valid = 1'b0;
  logic [15:0]    seed = '0;
  logic [N-1:0]   ready = '0;
  logic [N-1:0]   sat = '0;
  logic           ack = 1'b0;
  logic [N-1:0]   enable;
  logic [K-1:0]   index;
  logic           valid, fsat, err, busy;

  clause_check_scheduler #(
    .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(K),
    .LFSR_SEED(16'hACE1),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .in_clk(clk),
    .in_reset(rst_n),
    .in_start(start),
    .in_abort(abort),
    .in_seed_valid(seed_valid),
    .in_seed(seed),
    .in_checker_ready(ready),
    .in_clause_satisfied(sat),
    .in_ack(ack),
    .out_checker_enable(enable),
    .out_clause_index(index),
    .out_valid(valid),
    .out_formula_satisfied(fsat),
    .out_error(err),
    .out_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [K-1:0] idx;
    logic         fsat;
    logic         err;
    int           lat;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_pass = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start from IDLE and walks ENABLE into WAIT; returns the modelled start pointer.
  task automatic begin_pass(input logic sv, input logic [15:0] sd, output logic [K-1:0] ptr);
    seed_valid = sv;
    seed       = sd;
    start      = 1'b1;
    if (sv) m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
    ptr    = m_lfsr[K-1:0];
    m_lfsr = lfsr_next(m_lfsr);
    tick();
    start      = 1'b0;
    seed_valid = 1'b0;
    chk("enable_on", 32'(enable), 32'hFF);
    chk("busy_on", 32'(busy), 32'h1);
    tick();
    chk("enable_off", 32'(enable), 32'h0);
  endtask

  task automatic run_pass(input string tag, input logic sv, input logic [15:0] sd,
                          input logic [N-1:0] s, input int dly);
    logic [K-1:0] ptr;
    logic [K-1:0] p;
    exp_t         e;
    int           k;
    int           cnt;
    begin_pass(sv, sd, ptr);
    if (s == 8'hFF) begin
      e.idx = '0; e.fsat = 1'b1; e.lat = 1;
    end else begin
      p = ptr;
      k = 1;
      while (s[p]) begin
        p = p + 3'd1;
        k++;
      end
      e.idx = p; e.fsat = 1'b0; e.lat = 1 + k;
    end
    e.err = 1'b0;
    sb.push_back(e);
    repeat (dly) tick();
    ready = '1;
    sat   = s;
    cnt   = 0;
    while (valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    ready = '0;
    e = sb.pop_front();
    chk({tag, "/latency"}, 32'(cnt), 32'(e.lat));
    chk({tag, "/index"}, 32'(index), 32'(e.idx));
    chk({tag, "/fsat"}, 32'(fsat), 32'(e.fsat));
    chk({tag, "/err"}, 32'(err), 32'(e.err));
    start = 1'b1;  // must be ignored while DONE
    tick();
    chk({tag, "/hold_valid"}, 32'(valid), 32'h1);
    chk({tag, "/hold_index"}, 32'(index), 32'(e.idx));
    start = 1'b0;
    tick();
    chk({tag, "/hold_valid2"}, 32'(valid), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "/valid_drop"}, 32'(valid), 32'h0);
    chk({tag, "/idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [K-1:0] ptr;
    int           cnt;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_index", 32'(index), 32'h0);
    chk("rst_fsat", 32'(fsat), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_pass("seed5", 1'b1, 16'h0005, 8'b1101_1111, 3);
    run_pass("seed6", 1'b1, 16'h0006, 8'b1111_1101, 0);
    run_pass("allsat", 1'b0, 16'h0000, 8'hFF, 1);
    run_pass("seed0", 1'b1, 16'h0000, 8'b1110_1111, 2);

    // Reset in the middle of a scan
    begin_pass(1'b1, 16'h0006, ptr);
    ready = '1;
    sat   = 8'b1111_1101;
    tick();
    tick();
    chk("scan_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_enable", 32'(enable), 32'h0);
    chk("midrst_index", 32'(index), 32'h0);
    m_lfsr = 16'hACE1;
    ready  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_pass("post_rst", 1'b0, 16'h0000, 8'b1011_1111, 0);

    // Abort in WAIT; LFSR keeps its stepped value
    begin_pass(1'b0, 16'h0000, ptr);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_enable", 32'(enable), 32'h0);
    chk("abort_valid", 32'(valid), 32'h0);
    run_pass("post_abort", 1'b0, 16'h0000, 8'b0111_1111, 1);

    // Checkers never ready
    begin_pass(1'b0, 16'h0000, ptr);
    cnt = 0;
    while (valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
`ifdef CLAUSE_SCHED_TIMEOUT_EN
    chk("timeout_cycles", 32'(cnt), 32'(TIMEOUT));
    chk("timeout_err", 32'(err), 32'h1);
    chk("timeout_fsat", 32'(fsat), 32'h0);
    chk("timeout_index", 32'(index), 32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("timeout_idle", 32'(busy), 32'h0);
`else
    chk("wait_forever_valid", 32'(valid), 32'h0);
    chk("wait_forever_busy", 32'(busy), 32'h1);
    chk("wait_forever_err", 32'(err), 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wait_abort_idle", 32'(busy), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clause_check_scheduler.md
CLAUSE_CHECK_SCHEDULER -- requirements
Module: clause_check_scheduler

Interface
REQ-001 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, default 3, giving clause count N = 2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX.
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero reset value of the random-start LFSR.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit in WAIT (used only with the macro in REQ-025).
REQ-004 in_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 in_reset  input  1  asynchronous, active-low reset.
REQ-006 in_start  input  1  request one check-and-select pass; sampled only in IDLE.
REQ-007 in_abort  input  1  synchronous abort; returns to IDLE from any state.
REQ-008 in_seed_valid, in_seed  input  1, 16  load LFSR with in_seed when in IDLE; a zero value is replaced by LFSR_SEED.
REQ-009 in_checker_ready  input  N  per-clause checker ready flags.
REQ-010 in_clause_satisfied  input  N  per-clause satisfied flags, valid when all ready bits are 1.
REQ-011 in_ack  input  1  consumer accepts the result.
REQ-012 out_checker_enable  output  N  enable to all clause checkers.
REQ-013 out_clause_index  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX  selected unsatisfied clause.
REQ-014 out_valid, out_formula_satisfied, out_error, out_busy  output  1 each  result-valid, all-clauses-satisfied, watchdog-timeout, not-in-IDLE.

Function
REQ-015 States SHALL be IDLE, ENABLE, WAIT, SCAN, DONE; out_busy = (state != IDLE).
REQ-016 IDLE: in_start=1 at an edge -> ENABLE; at that edge start pointer <= LFSR[K-1:0] (K = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX) and the LFSR steps once; the LFSR does not step otherwise.
REQ-017 LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
REQ-018 in_seed_valid and in_start both high in IDLE: seed loads first, start pointer uses the loaded seed's low bits.
REQ-019 ENABLE: out_checker_enable = all ones for exactly one cycle, then WAIT; zero in all other states.
REQ-020 WAIT: when in_checker_ready is all ones, capture in_clause_satisfied into an internal register; if capture is all ones -> DONE with out_formula_satisfied=1, else -> SCAN.
REQ-021 SCAN: one clause per cycle starting at the start pointer, incrementing modulo N (wrap N-1 -> 0); the first captured bit equal to 0 sets out_clause_index to that index -> DONE; worst case N cycles.
REQ-022 DONE: out_valid=1 with outputs stable until a cycle with in_ack=1, then IDLE and out_valid=0 next cycle; in_start during DONE ignored.
REQ-023 in_abort SHALL take priority over all transitions; outputs cleared as in reset, LFSR retained.

Reset
REQ-024 While in_reset=0: state IDLE, LFSR=LFSR_SEED, all outputs 0, capture register 0, pointer 0.

Configuration
REQ-025 Macro CLAUSE_SCHED_TIMEOUT_EN defined: counter runs in WAIT; after TIMEOUT_CYCLES WAIT cycles without all-ready -> DONE with out_error=1, out_formula_satisfied=0, out_clause_index=0. Undefined: no counter, WAIT persists indefinitely, out_error tied 0.

Verification
REQ-026 Reset asserted mid-SCAN -> immediately IDLE, all outputs 0, LFSR=16'hACE1.
REQ-027 N=8, seed 16'h0005, start, ready all ones after 3 WAIT cycles, satisfied 8'b1101_1111 -> out_clause_index=5 after 1 SCAN cycle, out_valid held until in_ack.
REQ-028 Seed 16'h0006, satisfied 8'b1111_1101 -> SCAN visits 6,7,0,1 (4 cycles), out_clause_index=1.
REQ-029 Satisfied 8'hFF -> no SCAN cycle, out_valid=1, out_formula_satisfied=1.
REQ-030 Ready held 0, TIMEOUT_CYCLES=16: with macro out_error=1 after 16 WAIT cycles; without macro out_busy stays 1, out_valid stays 0.
REQ-031 in_abort in WAIT -> IDLE next cycle, out_checker_enable 0, subsequent in_start runs a full pass normally.
